// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle RV32I control unit and its datapath.
// The control unit is the master: it reads instruction-register fields and
// the ALU zero flag, and drives every datapath enable and mux select.
interface multicycle_control_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;

  logic       pcwrite;
  logic       adrsrc;
  logic       memwrite;
  logic       irwrite;
  logic [1:0] resultsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] immsrc;
  logic       regwrite;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct3, funct7b5, zero,
    output pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
           immsrc, regwrite, alucontrol, illegal, state
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
           immsrc, regwrite, alucontrol, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control unit for the multicycle RV32I core. A Moore FSM walks each
// instruction through fetch/decode/execute/memory/writeback on the shared
// datapath; small combinational decoders produce the immediate-format select
// and the ALU operation from the instruction-register fields.
module multicycle_control (
  input  logic              clk,
  input  logic              reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t     curstate;
  state_t     nextstate;

  logic       pcupdate;
  logic       branch;
  logic       adrsrc;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       illegal;
  logic [1:0] resultsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] immsrc;
  logic [2:0] alucontrol;

  // State register; reset drops whatever instruction was in flight.
  always_ff @(posedge clk) begin
    if (reset) curstate <= FETCH;
    else       curstate <= nextstate;
  end

  // Moore outputs and next-state selection; unused encodings fall back to FETCH.
  always_comb begin
    nextstate = FETCH;
    pcupdate  = 1'b0;
    branch    = 1'b0;
    adrsrc    = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    illegal   = 1'b0;
    resultsrc = 2'b00;
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    aluop     = 2'b00;
    case (curstate)
      FETCH: begin
        adrsrc    = 1'b0;
        irwrite   = 1'b1;
        alusrca   = 2'b00;
        alusrcb   = 2'b10;
        aluop     = 2'b00;
        resultsrc = 2'b10;
        pcupdate  = 1'b1;
        nextstate = DECODE;
      end
      DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        aluop   = 2'b00;
        case (bus.op)
          OP_LOAD, OP_STORE: nextstate = MEMADR;
          OP_RTYPE:          nextstate = EXECUTER;
          OP_ITYPE:          nextstate = EXECUTEI;
          OP_BRANCH:         nextstate = BEQ;
          OP_JAL:            nextstate = JAL;
          default: begin
            nextstate = FETCH;
            illegal   = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca   = 2'b10;
        alusrcb   = 2'b01;
        aluop     = 2'b00;
        nextstate = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adrsrc    = 1'b1;
        resultsrc = 2'b00;
        nextstate = MEMWB;
      end
      MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
        nextstate = FETCH;
      end
      MEMWRITE: begin
        adrsrc    = 1'b1;
        resultsrc = 2'b00;
        memwrite  = 1'b1;
        nextstate = FETCH;
      end
      EXECUTER: begin
        alusrca   = 2'b10;
        alusrcb   = 2'b00;
        aluop     = 2'b10;
        nextstate = ALUWB;
      end
      EXECUTEI: begin
        alusrca   = 2'b10;
        alusrcb   = 2'b01;
        aluop     = 2'b10;
        nextstate = ALUWB;
      end
      ALUWB: begin
        resultsrc = 2'b00;
        regwrite  = 1'b1;
        nextstate = FETCH;
      end
      JAL: begin
        alusrca   = 2'b01;
        alusrcb   = 2'b10;
        aluop     = 2'b00;
        resultsrc = 2'b00;
        pcupdate  = 1'b1;
        nextstate = ALUWB;
      end
      BEQ: begin
        alusrca   = 2'b10;
        alusrcb   = 2'b00;
        aluop     = 2'b01;
        resultsrc = 2'b00;
        branch    = 1'b1;
        nextstate = FETCH;
      end
      default: nextstate = FETCH;
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    immsrc = 2'b00;
    case (bus.op)
      OP_STORE:  immsrc = 2'b01;
      OP_BRANCH: immsrc = 2'b10;
      OP_JAL:    immsrc = 2'b11;
      default:   immsrc = 2'b00;
    endcase
  end

  // ALU decoder; op[5] separates R-type from I-type so addi never subtracts.
  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      2'b00: alucontrol = 3'b000;
      2'b01: alucontrol = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  alucontrol = (bus.funct7b5 & bus.op[5]) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

  assign bus.pcwrite    = ~reset & (pcupdate | (branch & bus.zero));
  assign bus.irwrite    = ~reset & irwrite;
  assign bus.memwrite   = ~reset & memwrite;
  assign bus.regwrite   = ~reset & regwrite;
  assign bus.illegal    = ~reset & illegal;
  assign bus.adrsrc     = adrsrc;
  assign bus.resultsrc  = resultsrc;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.immsrc     = immsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.state      = curstate;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for the multicycle control unit. Each instruction pushes its
// expected per-cycle control word into a queue; the queue is drained one
// entry per clock and compared against the live outputs.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] immsrc;
    logic       regwrite;
    logic [2:0] alucontrol;
    logic       illegal;
  } exp_t;

  logic clk;
  logic reset;
  int   assertCount;
  int   failCount;
  exp_t expq[$];

  multicycle_control_if bus();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Expected control word for one state, straight from the state table.
  function automatic exp_t mk(input logic [3:0] st, input logic [1:0] imm,
                              input logic [2:0] exalu, input logic z,
                              input logic ill);
    exp_t e;
    e        = '0;
    e.st     = st;
    e.immsrc = imm;
    case (st)
      4'd0: begin e.irwrite = 1; e.alusrcb = 2; e.resultsrc = 2; e.pcwrite = 1; end
      4'd1: begin e.alusrca = 1; e.alusrcb = 1; e.illegal = ill; end
      4'd2: begin e.alusrca = 2; e.alusrcb = 1; end
      4'd3: begin e.adrsrc = 1; end
      4'd4: begin e.resultsrc = 1; e.regwrite = 1; end
      4'd5: begin e.adrsrc = 1; e.memwrite = 1; end
      4'd6: begin e.alusrca = 2; e.alucontrol = exalu; end
      4'd7: begin e.alusrca = 2; e.alusrcb = 1; e.alucontrol = exalu; end
      4'd8: begin e.regwrite = 1; end
      4'd9: begin e.alusrca = 2; e.alucontrol = 3'b001; e.pcwrite = z; end
      4'd10: begin e.alusrca = 1; e.alusrcb = 2; e.pcwrite = 1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic compareWord(input exp_t e);
    checkOutput("state",      32'(bus.state),      32'(e.st));
    checkOutput("pcwrite",    32'(bus.pcwrite),    32'(e.pcwrite));
    checkOutput("adrsrc",     32'(bus.adrsrc),     32'(e.adrsrc));
    checkOutput("memwrite",   32'(bus.memwrite),   32'(e.memwrite));
    checkOutput("irwrite",    32'(bus.irwrite),    32'(e.irwrite));
    checkOutput("resultsrc",  32'(bus.resultsrc),  32'(e.resultsrc));
    checkOutput("alusrca",    32'(bus.alusrca),    32'(e.alusrca));
    checkOutput("alusrcb",    32'(bus.alusrcb),    32'(e.alusrcb));
    checkOutput("immsrc",     32'(bus.immsrc),     32'(e.immsrc));
    checkOutput("regwrite",   32'(bus.regwrite),   32'(e.regwrite));
    checkOutput("alucontrol", 32'(bus.alucontrol), 32'(e.alucontrol));
    checkOutput("illegal",    32'(bus.illegal),    32'(e.illegal));
  endtask

  // Pop one expected word per cycle, sampling mid-cycle.
  task automatic drainQueue();
    exp_t e;
    int   budget;
    budget = 0;
    while (expq.size() > 0 && budget < 20) begin
      @(negedge clk);
      #1;
      e = expq.pop_front();
      compareWord(e);
      budget++;
    end
    if (expq.size() != 0) begin
      checkOutput("queue_drain", 32'(expq.size()), 32'd0);
      expq.delete();
    end
  endtask

  // Drive one instruction (held for its whole life) and check its cycles.
  // maxCycles > 0 stops after that many cycles so the caller can interfere.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic f7, input logic z,
                               input logic [2:0] exalu, input int maxCycles);
    logic [3:0] path [0:4];
    logic [1:0] imm;
    logic       ill;
    int         n;
    bus.op       = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    bus.zero     = z;
    ill          = 1'b0;
    for (int i = 0; i < 5; i++) path[i] = 4'd0;
    path[1] = 4'd1;
    case (op)
      7'b0100011: imm = 2'b01;
      7'b1100011: imm = 2'b10;
      7'b1101111: imm = 2'b11;
      default:    imm = 2'b00;
    endcase
    case (op)
      7'b0000011: begin path[2] = 2; path[3] = 3; path[4] = 4; n = 5; end
      7'b0100011: begin path[2] = 2; path[3] = 5; n = 4; end
      7'b0110011: begin path[2] = 6; path[3] = 8; n = 4; end
      7'b0010011: begin path[2] = 7; path[3] = 8; n = 4; end
      7'b1100011: begin path[2] = 9; n = 3; end
      7'b1101111: begin path[2] = 10; path[3] = 8; n = 4; end
      default:    begin n = 2; ill = 1'b1; end
    endcase
    if (maxCycles > 0 && maxCycles < n) n = maxCycles;
    for (int i = 0; i < n; i++) expq.push_back(mk(path[i], imm, exalu, z, ill));
    drainQueue();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    assertCount  = 0;
    failCount    = 0;
    reset        = 1'b1;
    bus.op       = 7'b0;
    bus.funct3   = 3'b0;
    bus.funct7b5 = 1'b0;
    bus.zero     = 1'b0;

    // Two cycles in reset: state parked at FETCH, all write enables low.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checkOutput("rst_state",    32'(bus.state),    32'd0);
      checkOutput("rst_pcwrite",  32'(bus.pcwrite),  32'd0);
      checkOutput("rst_irwrite",  32'(bus.irwrite),  32'd0);
      checkOutput("rst_memwrite", 32'(bus.memwrite), 32'd0);
      checkOutput("rst_regwrite", 32'(bus.regwrite), 32'd0);
      checkOutput("rst_illegal",  32'(bus.illegal),  32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, 3'b000, 0); // lw
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b1, 3'b000, 0); // sw
    applyStimulus(7'b0110011, 3'b000, 1'b0, 1'b1, 3'b000, 0); // add
    applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0, 3'b001, 0); // sub
    applyStimulus(7'b0010011, 3'b000, 1'b1, 1'b1, 3'b000, 0); // addi, instr[30]=1
    applyStimulus(7'b0110011, 3'b010, 1'b0, 1'b0, 3'b101, 0); // slt
    applyStimulus(7'b0010011, 3'b110, 1'b0, 1'b0, 3'b011, 0); // ori
    applyStimulus(7'b0010011, 3'b111, 1'b0, 1'b0, 3'b010, 0); // andi
    applyStimulus(7'b0110011, 3'b001, 1'b1, 1'b0, 3'b000, 0); // sll -> add code
    applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b1, 3'b000, 0); // beq taken
    applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b0, 3'b000, 0); // beq not taken
    applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b0, 3'b000, 0); // illegal
    applyStimulus(7'b0110111, 3'b000, 1'b0, 1'b1, 3'b000, 0); // lui unsupported
    applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0, 3'b000, 0); // jal

    // sw interrupted by reset while in MEMWRITE: no write may escape.
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 3'b000, 3);
    reset       = 1'b1;
    e           = mk(4'd5, 2'b01, 3'b000, 1'b0, 1'b0);
    e.memwrite  = 1'b0;
    expq.push_back(e);
    drainQueue();
    @(posedge clk);
    #1;
    e           = mk(4'd0, 2'b01, 3'b000, 1'b0, 1'b0);
    e.pcwrite   = 1'b0;
    e.irwrite   = 1'b0;
    expq.push_back(e);
    drainQueue();
    @(posedge clk);
    #1;
    reset = 1'b0;

    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b1, 3'b000, 0); // lw after recovery
    applyStimulus(7'b1100011, 3'b000, 1'b1, 1'b1, 3'b000, 0); // beq taken again

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
